// File: rtl/pqsdn_ram_pkg.sv
// Shared definitions for the pqsdn table RAM with clear engine.
//   state_e      : clear-engine FSM states (idle, drain pending write, clear sweep)
//   rd_lat_legal : elaboration-time check for the supported read latencies
package pqsdn_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLR   = 2'd2
  } state_e;

  // Only one or two output register stages are implemented.
  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat == 32'd1) || (lat == 32'd2);
  endfunction

endpackage

// File: rtl/pqsdn_ram_clr_fsm.sv
// Clear-engine controller for pqsdn_ram_clr.
// Owns the state register and the clear address counter, and decodes the port
// ready, busy and zero-write controls from the state register.
//   clk, rst     : clock, synchronous active-high reset
//   clr_i        : clear request, only honoured in ST_IDLE
//   wr_rdy_o     : write port may accept
//   rd_rdy_o     : read port may accept
//   clr_busy_o   : drain or clear in progress
//   clr_we_o     : zero-write enable for the array
//   clr_addr_o   : zero-write address
module pqsdn_ram_clr_fsm
  import pqsdn_ram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  output logic              wr_rdy_o,
  output logic              rd_rdy_o,
  output logic              clr_busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  localparam state_e           RstState = (CLR_ON_RST != 0) ? ST_CLR : ST_IDLE;
  localparam logic [ADDR_W-1:0] CntLast = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_i) state_d = ST_DRAIN;
      end
      // The pending write commits during this cycle, so the sweep cannot be
      // overtaken by a late write.
      ST_DRAIN: begin
        state_d = ST_CLR;
      end
      ST_CLR: begin
        if (clr_cnt_q == CntLast) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RstState;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // All controls decode straight from the state register.
  assign wr_rdy_o   = (state_q == ST_IDLE);
  assign rd_rdy_o   = (state_q == ST_IDLE);
  assign clr_busy_o = (state_q != ST_IDLE);
  assign clr_we_o   = (state_q == ST_CLR);
  assign clr_addr_o = clr_cnt_q;

endmodule

// File: rtl/pqsdn_ram_clr.sv
// Simple-dual-port table RAM for pqsdn with byte enables, write-to-read
// bypass, 1- or 2-cycle read latency and a whole-array clear engine.
//   clk, rst      : clock, synchronous active-high reset
//   wr_*_a_i      : write port (enable, byte enables, address, data)
//   wr_rdy_o      : write port ready; writes while not ready are dropped
//   rd_en_b_i     : read request, rd_addr_b_i its address
//   rd_rdy_o      : read port ready; reads while not ready are dropped
//   rd_vld_o      : one-cycle pulse RD_LAT cycles after an accepted read
//   rd_data_o     : read data, held while rd_vld_o is low
//   clr_i         : clear request (level or pulse)
//   clr_busy_o    : drain or clear in progress
module pqsdn_ram_clr
  import pqsdn_ram_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned BE_W       = DATA_W / 8,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned BYPASS     = 1,
  parameter int unsigned CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_a_i,
  input  logic [BE_W-1:0]   wr_be_a_i,
  input  logic [ADDR_W-1:0] wr_addr_a_i,
  input  logic [DATA_W-1:0] wr_data_a_i,
  output logic              wr_rdy_o,
  input  logic              rd_en_b_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              rd_rdy_o,
  output logic              rd_vld_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              clr_i,
  output logic              clr_busy_o
);

  localparam int unsigned Depth    = 2 ** ADDR_W;
  localparam bit          BypassEn = (BYPASS != 0);

  if (!rd_lat_legal(RD_LAT)) begin : gen_bad_rd_lat
    $error("pqsdn_ram_clr: RD_LAT must be 1 or 2");
  end
  if ((DATA_W % 8 != 0) || (BE_W != DATA_W / 8)) begin : gen_bad_width
    $error("pqsdn_ram_clr: DATA_W must be a multiple of 8 and BE_W = DATA_W/8");
  end

  // ---------------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------------
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  pqsdn_ram_clr_fsm #(
    .ADDR_W     (ADDR_W),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_i),
    .wr_rdy_o   (wr_rdy_o),
    .rd_rdy_o   (rd_rdy_o),
    .clr_busy_o (clr_busy_o),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic wr_acc;
  logic rd_acc;

  assign wr_acc = wr_en_a_i & wr_rdy_o;
  assign rd_acc = rd_en_b_i & rd_rdy_o;

  // ---------------------------------------------------------------------------
  // Pending write stage: one cycle between acceptance and array commit
  // ---------------------------------------------------------------------------
  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [BE_W-1:0]   pend_be_q, pend_be_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;

  always_comb begin
    pend_vld_d  = wr_acc;
    pend_addr_d = pend_addr_q;
    pend_be_d   = pend_be_q;
    pend_data_d = pend_data_q;
    if (wr_acc) begin
      pend_addr_d = wr_addr_a_i;
      pend_be_d   = wr_be_a_i;
      pend_data_d = wr_data_a_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q  <= 1'b0;
      pend_addr_q <= '0;
      pend_be_q   <= '0;
      pend_data_q <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_addr_q <= pend_addr_d;
      pend_be_q   <= pend_be_d;
      pend_data_q <= pend_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array. A pending write never coexists with the clear sweep (DRAIN
  // empties the stage and nothing is accepted while clearing), so the two
  // write sources are mutually exclusive.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (pend_vld_q) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (pend_be_q[b]) mem_q[pend_addr_q][8*b +: 8] <= pend_data_q[8*b +: 8];
      end
    end else if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: array sample plus bypass from the pending stage. The write
  // accepted in the same cycle is still outside the pending stage, which
  // gives read-first behaviour.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] rd_merge;

  always_comb begin
    rd_merge = mem_q[rd_addr_b_i];
    if (BypassEn && pend_vld_q && (pend_addr_q == rd_addr_b_i)) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (pend_be_q[b]) rd_merge[8*b +: 8] = pend_data_q[8*b +: 8];
      end
    end
  end

  logic              rd_vld1_q, rd_vld1_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;

  always_comb begin
    rd_vld1_d  = rd_acc;
    rd_data1_d = rd_acc ? rd_merge : rd_data1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld1_q  <= 1'b0;
      rd_data1_q <= '0;
    end else begin
      rd_vld1_q  <= rd_vld1_d;
      rd_data1_q <= rd_data1_d;
    end
  end

  if (RD_LAT == 2) begin : gen_lat2
    logic              rd_vld2_q;
    logic [DATA_W-1:0] rd_data2_q, rd_data2_d;

    always_comb begin
      rd_data2_d = rd_vld1_q ? rd_data1_q : rd_data2_q;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rd_vld2_q  <= 1'b0;
        rd_data2_q <= '0;
      end else begin
        rd_vld2_q  <= rd_vld1_q;
        rd_data2_q <= rd_data2_d;
      end
    end

    assign rd_vld_o  = rd_vld2_q;
    assign rd_data_o = rd_data2_q;
  end else begin : gen_lat1
    assign rd_vld_o  = rd_vld1_q;
    assign rd_data_o = rd_data1_q;
  end

endmodule

// File: tb/tb_pqsdn_ram_clr.sv
// Bench for pqsdn_ram_clr. Three instances share one stimulus stream:
//   a: RD_LAT=1 BYPASS=1, b: RD_LAT=1 BYPASS=0, c: RD_LAT=2 BYPASS=1.
// A reference model checks every output of every instance each cycle; a
// directed table and a few hand sequences add explicit expected values.
module tb_pqsdn_ram_clr;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 4;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [BW-1:0] wr_be = '0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          clr = 1'b0;

  logic [2:0]    wr_rdy_w, rd_rdy_w, vld_w, busy_w;
  logic [DW-1:0] dat_w [3];

  always #5 clk = ~clk;

  pqsdn_ram_clr #(
    .DATA_W(DW), .ADDR_W(AW), .BE_W(BW), .RD_LAT(1), .BYPASS(1), .CLR_ON_RST(1)
  ) u_dut_a (
    .clk(clk), .rst(rst), .wr_en_a_i(wr_en), .wr_be_a_i(wr_be), .wr_addr_a_i(wr_addr),
    .wr_data_a_i(wr_data), .wr_rdy_o(wr_rdy_w[0]), .rd_en_b_i(rd_en), .rd_addr_b_i(rd_addr),
    .rd_rdy_o(rd_rdy_w[0]), .rd_vld_o(vld_w[0]), .rd_data_o(dat_w[0]), .clr_i(clr),
    .clr_busy_o(busy_w[0])
  );

  pqsdn_ram_clr #(
    .DATA_W(DW), .ADDR_W(AW), .BE_W(BW), .RD_LAT(1), .BYPASS(0), .CLR_ON_RST(1)
  ) u_dut_b (
    .clk(clk), .rst(rst), .wr_en_a_i(wr_en), .wr_be_a_i(wr_be), .wr_addr_a_i(wr_addr),
    .wr_data_a_i(wr_data), .wr_rdy_o(wr_rdy_w[1]), .rd_en_b_i(rd_en), .rd_addr_b_i(rd_addr),
    .rd_rdy_o(rd_rdy_w[1]), .rd_vld_o(vld_w[1]), .rd_data_o(dat_w[1]), .clr_i(clr),
    .clr_busy_o(busy_w[1])
  );

  pqsdn_ram_clr #(
    .DATA_W(DW), .ADDR_W(AW), .BE_W(BW), .RD_LAT(2), .BYPASS(1), .CLR_ON_RST(1)
  ) u_dut_c (
    .clk(clk), .rst(rst), .wr_en_a_i(wr_en), .wr_be_a_i(wr_be), .wr_addr_a_i(wr_addr),
    .wr_data_a_i(wr_data), .wr_rdy_o(wr_rdy_w[2]), .rd_en_b_i(rd_en), .rd_addr_b_i(rd_addr),
    .rd_rdy_o(rd_rdy_w[2]), .rd_vld_o(vld_w[2]), .rd_data_o(dat_w[2]), .clr_i(clr),
    .clr_busy_o(busy_w[2])
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model. mem_bp holds every write accepted in earlier cycles (what
  // a bypassing read sees); mem_nb lags it by one cycle (what a read sees
  // without bypass). busy_left counts the remaining not-ready cycles.
  // ---------------------------------------------------------------------------
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_exp_t;

  logic [DW-1:0] mem_bp [DEPTH];
  logic [DW-1:0] mem_nb [DEPTH];
  logic [DW-1:0] held [3];
  rd_exp_t       q0[$], q1[$], q2[$];
  bit            lag_v = 1'b0;
  logic [AW-1:0] lag_a;
  logic [BW-1:0] lag_be;
  logic [DW-1:0] lag_d;
  int            busy_left = 0;
  bit            mdl_on = 1'b0;
  int            cyc = 0;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_bp[i] = '0;
      mem_nb[i] = '0;
    end
    for (int d = 0; d < 3; d++) held[d] = '0;
  end

  initial begin
    logic [2:0]    ev;
    logic [DW-1:0] vb, vn;
    bit            rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (mdl_on) begin
        ev = '0;
        if (q0.size() > 0 && q0[0].due == cyc) begin
          ev[0] = 1'b1; held[0] = q0[0].data; void'(q0.pop_front());
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
          ev[1] = 1'b1; held[1] = q1[0].data; void'(q1.pop_front());
        end
        if (q2.size() > 0 && q2[0].due == cyc) begin
          ev[2] = 1'b1; held[2] = q2[0].data; void'(q2.pop_front());
        end
        for (int d = 0; d < 3; d++) begin
          chk($sformatf("mdl rd_vld[%0d]", d), DW'(vld_w[d]), DW'(ev[d]));
          chk($sformatf("mdl rd_data[%0d]", d), dat_w[d], held[d]);
          chk($sformatf("mdl wr_rdy[%0d]", d), DW'(wr_rdy_w[d]), DW'(busy_left == 0));
          chk($sformatf("mdl rd_rdy[%0d]", d), DW'(rd_rdy_w[d]), DW'(busy_left == 0));
          chk($sformatf("mdl busy[%0d]", d), DW'(busy_w[d]), DW'(busy_left != 0));
        end
      end
      // Apply the effect of the coming clock edge.
      if (rst) begin
        busy_left = DEPTH;
        lag_v     = 1'b0;
        q0.delete(); q1.delete(); q2.delete();
        for (int d = 0; d < 3; d++) held[d] = '0;
        mdl_on    = 1'b1;
      end else begin
        rdy = (busy_left == 0);
        if (rdy && rd_en) begin
          vb = mem_bp[rd_addr];
          vn = mem_nb[rd_addr];
          q0.push_back('{cyc + 1, vb});
          q1.push_back('{cyc + 1, vn});
          q2.push_back('{cyc + 2, vb});
        end
        if (lag_v) mem_nb[lag_a] = merge(mem_nb[lag_a], lag_d, lag_be);
        lag_v = 1'b0;
        if (rdy && wr_en) begin
          mem_bp[wr_addr] = merge(mem_bp[wr_addr], wr_data, wr_be);
          lag_v  = 1'b1;
          lag_a  = wr_addr;
          lag_be = wr_be;
          lag_d  = wr_data;
        end
        if (busy_left > 0) begin
          busy_left--;
          if (busy_left == 0) begin
            for (int i = 0; i < DEPTH; i++) begin
              mem_bp[i] = '0;
              mem_nb[i] = '0;
            end
          end
        end else if (clr) begin
          busy_left = DEPTH + 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Directed vectors (one row per cycle; ex = bypassing read, ex_nb = no bypass)
  // ---------------------------------------------------------------------------
  typedef struct {
    bit            wr;
    logic [BW-1:0] be;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    bit            rd;
    logic [AW-1:0] ra;
    logic [DW-1:0] ex;
    logic [DW-1:0] ex_nb;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  task automatic drive_idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic count_busy(input bit spam, output int n);
    n = 0;
    while (busy_w[0] && n < 100) begin
      if (spam) begin
        wr_en = 1'b1; wr_be = '1; wr_addr = AW'(2); wr_data = 64'hDEAD_BEEF;
        rd_en = 1'b1; rd_addr = AW'(2);
      end
      n++;
      @(posedge clk); #1;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0]  = '{1'b1, 8'hFF, 4'd3, 64'h1122334455667788, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[1]  = '{1'b1, 8'h0F, 4'd3, 64'hAAAAAAAAAAAAAAAA, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[2]  = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[3]  = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd3, 64'h11223344AAAAAAAA,
                64'h11223344AAAAAAAA};
    tbl[4]  = '{1'b1, 8'hFF, 4'd5, 64'hFFFF0000FFFF0000, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[5]  = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd5, 64'hFFFF0000FFFF0000, 64'd0};
    tbl[6]  = '{1'b1, 8'hFF, 4'd7, 64'h9, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[7]  = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[8]  = '{1'b1, 8'hFF, 4'd7, 64'h1, 1'b1, 4'd7, 64'h9, 64'h9};
    tbl[9]  = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd7, 64'h1, 64'h9};
    tbl[10] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd7, 64'h1, 64'h1};
    tbl[11] = '{1'b1, 8'h00, 4'd9, 64'hFFFFFFFFFFFFFFFF, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[12] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd9, 64'd0, 64'd0};
    tbl[13] = '{1'b1, 8'hFF, 4'd0, 64'd10, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[14] = '{1'b1, 8'hFF, 4'd1, 64'd11, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[15] = '{1'b1, 8'hFF, 4'd2, 64'd12, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[16] = '{1'b1, 8'hFF, 4'd3, 64'd13, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[17] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b0, 4'd0, 64'd0, 64'd0};
    tbl[18] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd0, 64'd10, 64'd10};
    tbl[19] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd1, 64'd11, 64'd11};
    tbl[20] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd2, 64'd12, 64'd12};
    tbl[21] = '{1'b0, 8'h00, 4'd0, 64'd0, 1'b1, 4'd3, 64'd13, 64'd13};

    // Reset held for three cycles, then the post-reset clear.
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", DW'(busy_w), DW'(3'b111));
    chk("reset wr_rdy", DW'(wr_rdy_w), DW'(3'b000));
    chk("reset rd_rdy", DW'(rd_rdy_w), DW'(3'b000));
    chk("reset rd_vld", DW'(vld_w), DW'(3'b000));
    chk("reset rd_data", dat_w[0], 64'd0);
    rst = 1'b0;
    count_busy(1'b0, n);
    chk("post-reset not-ready cycles", DW'(n), DW'(DEPTH));

    for (int a = 0; a <= DEPTH; a++) begin
      if (a > 0) begin
        chk("cleared rd_vld", DW'(vld_w[0]), 64'd1);
        chk("cleared rd_data", dat_w[0], 64'd0);
      end
      rd_en   = (a < DEPTH);
      rd_addr = AW'(a);
      @(posedge clk); #1;
    end
    drive_idle();

    // Table: lat-1 results of row i-1 and lat-2 results of row i-2 are visible
    // just after each edge.
    for (int i = 0; i < NV + 2; i++) begin
      if (i >= 1 && i <= NV && tbl[i-1].rd) begin
        chk($sformatf("tbl%0d a vld", i - 1), DW'(vld_w[0]), 64'd1);
        chk($sformatf("tbl%0d a data", i - 1), dat_w[0], tbl[i-1].ex);
        chk($sformatf("tbl%0d b data", i - 1), dat_w[1], tbl[i-1].ex_nb);
      end
      if (i >= 2 && tbl[i-2].rd) begin
        chk($sformatf("tbl%0d c vld", i - 2), DW'(vld_w[2]), 64'd1);
        chk($sformatf("tbl%0d c data", i - 2), dat_w[2], tbl[i-2].ex);
      end
      if (i < NV) begin
        wr_en = tbl[i].wr; wr_be = tbl[i].be; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
        rd_en = tbl[i].rd; rd_addr = tbl[i].ra;
      end else begin
        drive_idle();
      end
      @(posedge clk); #1;
    end
    drive_idle();

    // Clear request with a write and a back-to-back read in flight.
    wr_en = 1'b1; wr_be = '1; wr_addr = AW'(2); wr_data = 64'h55;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = AW'(2); clr = 1'b1;
    @(posedge clk); #1;
    rd_en = 1'b0; clr = 1'b0;
    chk("clr inflight rd_vld", DW'(vld_w[0]), 64'd1);
    chk("clr inflight rd_data", dat_w[0], 64'h55);
    count_busy(1'b1, n);
    chk("clear busy cycles", DW'(n), DW'(DEPTH + 1));
    rd_en = 1'b1; rd_addr = AW'(2);
    @(posedge clk); #1;
    rd_en = 1'b0;
    chk("after clear a data", dat_w[0], 64'd0);
    chk("after clear b data", dat_w[1], 64'd0);

    // Reset in the middle of a clear restarts the full sweep.
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_busy(1'b0, n);
    chk("mid-clear reset busy cycles", DW'(n), DW'(DEPTH));

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      rst     = ($urandom_range(0, 499) == 0);
      clr     = ($urandom_range(0, 99) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      wr_be   = BW'($urandom);
      wr_addr = AW'($urandom);
      wr_data = {$urandom, $urandom};
      rd_en   = ($urandom_range(0, 3) != 0);
      rd_addr = AW'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    drive_idle();
    repeat (5) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
